instruction_fetch: RTL

Instruction fetch stage of the 64-bit five-stage pipeline. It owns the program counter and issues one-at-a-time requests to instruction memory over a valid/ready handshake. It delivers each fetched 32-bit instruction with its PC to the IF/ID pipeline register. It honours the hazard unit's stall (`pc_write`) and the branch/jump redirect from EX, discarding any in-flight wrong-path fetch.

---
 rtl/instruction_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the 64-bit five-stage pipeline.
// Owns the program counter, issues one outstanding instruction-memory request
// at a time over a valid/ready handshake, and presents each returned word with
// its PC to the IF/ID register. Honours the hazard-unit stall (pc_write) and
// EX redirects, discarding any wrong-path response still in flight.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [63:0] if_pc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Clears the byte-offset bits so every fetch address is word-aligned.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return addr & ~64'h0000_0000_0000_0003;
  endfunction

  // Sequential PC; addition is modulo 2^64 so the top word wraps to zero.
  function automatic logic [63:0] next_word(input logic [63:0] addr);
    return addr + 64'd4;
  endfunction

  state_t      state_r, state_s;
  logic [63:0] pc_r, pc_s;
  logic        if_valid_r, if_valid_s;
  logic [31:0] if_instruction_r, if_instruction_s;
  logic [63:0] if_pc_r, if_pc_s;

  logic        req_s;
  logic        handshake_s;
  logic        consume_s;

  // A request is only raised in FETCH when the output slot is free or being
  // consumed, and never while a redirect (or reset) is pending this cycle.
  assign req_s       = (state_r == ST_FETCH) && !redirect_valid && !reset &&
                       (!if_valid_r || pc_write);
  assign handshake_s = req_s && imem_ready;
  assign consume_s   = if_valid_r && pc_write;

  assign imem_req       = req_s;
  assign imem_addr      = pc_r;
  assign if_valid       = if_valid_r;
  assign if_instruction = if_instruction_r;
  assign if_pc          = if_pc_r;

  // Next-state and next-register computation; redirect overrides normal flow.
  always_comb begin
    state_s          = state_r;
    pc_s             = pc_r;
    if_valid_s       = if_valid_r;
    if_instruction_s = if_instruction_r;
    if_pc_s          = if_pc_r;

    if (redirect_valid) begin
      pc_s             = align_word(redirect_pc);
      if_valid_s       = 1'b0;
      if_instruction_s = NOP_INSN;
      case (state_r)
        ST_FETCH: state_s = handshake_s ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  state_s = imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_DRAIN: state_s = imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_s = ST_FETCH;
      endcase
    end else begin
      // Consumed slot empties unless a fresh response is loaded below.
      if (consume_s) begin
        if_valid_s       = 1'b0;
        if_instruction_s = NOP_INSN;
      end else begin
        if_valid_s       = if_valid_r;
      end
      case (state_r)
        ST_FETCH: begin
          if (handshake_s) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if_instruction_s = imem_rdata;
            if_pc_s          = pc_r;
            if_valid_s       = 1'b1;
            pc_s             = next_word(pc_r);
            state_s          = ST_FETCH;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: state_s = ST_FETCH;
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_FETCH;
      pc_r             <= align_word(RESET_PC);
      if_valid_r       <= 1'b0;
      if_instruction_r <= NOP_INSN;
      if_pc_r          <= 64'h0;
    end else begin
      state_r          <= state_s;
      pc_r             <= pc_s;
      if_valid_r       <= if_valid_s;
      if_instruction_r <= if_instruction_s;
      if_pc_r          <= if_pc_s;
    end
  end

endmodule
